store_block: RTL

Store-side counterpart to the move/load path of the floating-point co-processor. It accepts store requests naming a source register, reads that register from the register file through a one-cycle-latency read port, and presents the 32-bit operand to the host side on a valid/ready handshake. A 2-entry request queue lets the sequencer issue stores while a previous store is still waiting for the host.

---
 rtl/store_block.sv | 116 +++++++++++
 1 files changed

// File: rtl/store_block.sv
// Store path: queues store requests, reads the register file, and hands the operand to the host on valid/ready.
// Optional build macro STORE_BLOCK_PARITY_EN adds the out_parity output.
module store_block #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic [3:0]  src_in,
  output logic        full,
  output logic        overflow,
  output logic        rf_rd_en,
  output logic [3:0]  rf_sel,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand,
  output logic [3:0]  out_src,
`ifdef STORE_BLOCK_PARITY_EN
  output logic        done,
  output logic        out_parity
`else
  output logic        done
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, DRIVE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  q_mem [DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  q_cnt;
  logic        empty, pop, push, hs;

  assign empty = (q_cnt == 2'd0);
  assign full  = (q_cnt == 2'(DEPTH));
  assign hs    = out_valid & out_ready;
  // A full queue can still take a request in the cycle its head is popped
  assign push  = enable & (~full | pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = READ;
      end
      READ:  state_nxt = CAPT;
      CAPT:  state_nxt = DRIVE;
      DRIVE: if (hs) begin
        pop       = ~empty;
        state_nxt = empty ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      q_cnt    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= src_in;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
      if (enable && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_rd_en    <= 1'b0;
      rf_sel      <= '0;
      out_valid   <= 1'b0;
      out_operand <= '0;
      out_src     <= '0;
      done        <= 1'b0;
    end else begin
      rf_rd_en <= pop;
      done     <= hs;
      if (pop) rf_sel <= q_mem[rd_ptr];
      // rf_sel is still the index read two cycles ago, so it tags the captured data
      if (state == CAPT) begin
        out_valid   <= 1'b1;
        out_operand <= rf_data;
        out_src     <= rf_sel;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STORE_BLOCK_PARITY_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              out_parity <= 1'b0;
    else if (state == CAPT) out_parity <= ^rf_data;
  end
`endif

endmodule
